// File: rtl/engine_snd_pkg.sv
// Shared engine-sound definitions: sequencer state encoding and default pulse periods.
// Also used by the top-level sound mux.
package engine_snd_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    IDLE      = 3'd1,
    RAMP_UP   = 3'd2,
    REV       = 3'd3,
    RAMP_DOWN = 3'd4
  } eng_state_e;

  localparam int IDLE_PERIOD_DEF = 6000;
  localparam int REV_PERIOD_DEF  = 2000;

endpackage

// File: rtl/period_pulse_gen.sv
// Reloadable down-counter that emits one tick-aligned pulse every `period` ticks while run=1.
// The first tick after run rises loads the counter without pulsing.
module period_pulse_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_3MHz_en,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                pulse
);

  logic [PERIOD_W-1:0] tick_cnt;
  logic                armed;

  assign pulse = rst & clk_3MHz_en & run & armed & (tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
      armed    <= 1'b0;
    end else if (clk_3MHz_en) begin
      if (!run) begin
        tick_cnt <= '0;
        armed    <= 1'b0;
      end else if (!armed || tick_cnt == '0) begin
        tick_cnt <= period - PERIOD_W'(1);
        armed    <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt - PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/engine_rev_sched.sv
// Engine rev sequencer: turns engine_on/rev_req into LFO rev pulses whose period glides
// between IDLE_PERIOD and REV_PERIOD in RAMP_STEP increments every RAMP_DIV pulses.
module engine_rev_sched import engine_snd_pkg::*; #(
  parameter int PERIOD_W    = 16,
  parameter int IDLE_PERIOD = IDLE_PERIOD_DEF,
  parameter int REV_PERIOD  = REV_PERIOD_DEF,
  parameter int RAMP_STEP   = 50,
  parameter int RAMP_DIV    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_3MHz_en,
  input  logic                engine_on,
  input  logic                rev_req,
  output logic                engine_rev_en,
  output logic [PERIOD_W-1:0] cur_period,
  output logic [2:0]          state_o,
  output logic                ramping
);

  localparam int DIV_W = $clog2(RAMP_DIV) + 1;
  localparam logic [PERIOD_W:0]  IDLE_X   = (PERIOD_W+1)'(IDLE_PERIOD);
  localparam logic [PERIOD_W:0]  REV_X    = (PERIOD_W+1)'(REV_PERIOD);
  localparam logic [PERIOD_W:0]  STEP_X   = (PERIOD_W+1)'(RAMP_STEP);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);

  eng_state_e          state, state_nx;
  logic [PERIOD_W-1:0] period_nx;
  logic [DIV_W-1:0]    div_cnt, div_nx;
  logic [PERIOD_W:0]   cur_x, up_sum, step_dn, step_up;
  logic                div_hit;

  period_pulse_gen #(.PERIOD_W(PERIOD_W)) u_pulse (
    .clk         (clk),
    .rst         (rst),
    .clk_3MHz_en (clk_3MHz_en),
    .run         (engine_on),
    .period      (cur_period),
    .pulse       (engine_rev_en)
  );

  assign state_o = state;
  assign ramping = (state == RAMP_UP) || (state == RAMP_DOWN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= OFF;
      cur_period <= PERIOD_W'(IDLE_PERIOD);
      div_cnt    <= '0;
    end else if (clk_3MHz_en) begin
      state      <= state_nx;
      cur_period <= period_nx;
      div_cnt    <= div_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    period_nx = cur_period;
    div_nx    = div_cnt;
    // widened by one bit so the saturating step cannot wrap
    cur_x   = {1'b0, cur_period};
    up_sum  = cur_x + STEP_X;
    step_dn = (cur_x <= REV_X + STEP_X) ? REV_X : cur_x - STEP_X;
    step_up = (up_sum >= IDLE_X) ? IDLE_X : up_sum;
    div_hit = engine_rev_en && (div_cnt == DIV_LAST);

    if (!engine_on) begin
      state_nx  = OFF;
      period_nx = PERIOD_W'(IDLE_PERIOD);
    end else begin
      case (state)
        OFF:  state_nx = IDLE;
        IDLE: if (rev_req) state_nx = RAMP_UP;
        RAMP_UP: begin
          if (!rev_req) begin
            state_nx = RAMP_DOWN;
          end else if (div_hit) begin
            period_nx = PERIOD_W'(step_dn);
            div_nx    = '0;
            if (step_dn == REV_X) state_nx = REV;
          end else if (engine_rev_en) begin
            div_nx = div_cnt + DIV_W'(1);
          end
        end
        REV: if (!rev_req) state_nx = RAMP_DOWN;
        RAMP_DOWN: begin
          if (rev_req) begin
            state_nx = RAMP_UP;
          end else if (div_hit) begin
            period_nx = PERIOD_W'(step_up);
            div_nx    = '0;
            if (step_up == IDLE_X) state_nx = IDLE;
          end else if (engine_rev_en) begin
            div_nx = div_cnt + DIV_W'(1);
          end
        end
        default: state_nx = OFF;
      endcase
    end

    if (state_nx != state) div_nx = '0;
  end

endmodule

// File: tb/tb_engine_rev_sched.sv
// Directed bench for engine_rev_sched: IDLE=10, REV=4, DIV=2, STEP=2 (u_dut) and STEP=4 (u_dut4),
// with the 3 MHz enable high on every third clk.
module tb_engine_rev_sched;
  import engine_snd_pkg::*;

  logic        clk, rst, en, engine_on, rev_req, rev_req4, en_hold;
  logic        engine_rev_en, engine_rev_en4, ramping, ramping4;
  logic [15:0] cur_period, cur_period4;
  logic [2:0]  state_o, state4;

  int n_checks = 0, n_errors = 0;
  int tick_no = 0, pulse_cnt = 0, pulse4_cnt = 0;
  logic pulse_now;
  int ph = 0;

  engine_rev_sched #(.PERIOD_W(16), .IDLE_PERIOD(10), .REV_PERIOD(4), .RAMP_STEP(2), .RAMP_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .clk_3MHz_en(en), .engine_on(engine_on), .rev_req(rev_req),
    .engine_rev_en(engine_rev_en), .cur_period(cur_period), .state_o(state_o), .ramping(ramping));

  engine_rev_sched #(.PERIOD_W(16), .IDLE_PERIOD(10), .REV_PERIOD(4), .RAMP_STEP(4), .RAMP_DIV(2)) u_dut4 (
    .clk(clk), .rst(rst), .clk_3MHz_en(en), .engine_on(engine_on), .rev_req(rev_req4),
    .engine_rev_en(engine_rev_en4), .cur_period(cur_period4), .state_o(state4), .ramping(ramping4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph == 2) ? 0 : ph + 1;
      en = (ph == 0) && !en_hold;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (en) tick_no++;
    pulse_now = engine_rev_en;
    if (engine_rev_en) begin
      chk("pulse_on_tick", {31'd0, en}, 1);
      pulse_cnt++;
    end
    if (engine_rev_en4) begin
      chk("pulse4_on_tick", {31'd0, en}, 1);
      pulse4_cnt++;
    end
  endtask

  // returns the tick index of the next pulse, then steps past its clock edge
  task automatic wait_pulse(input bit which, output int t);
    int c0;
    c0 = which ? pulse4_cnt : pulse_cnt;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if ((which ? pulse4_cnt : pulse_cnt) != c0) begin
        t = tick_no;
        cyc();
        return;
      end
    end
    chk("pulse_timeout", 0, 1);
    t = tick_no;
  endtask

  task automatic wait_pulses(input bit which, input int n);
    int t;
    for (int i = 0; i < n; i++) wait_pulse(which, t);
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_no + n;
    for (int i = 0; i < 1000 && tick_no < target; i++) cyc();
    if (tick_no < target) chk("tick_timeout", 0, 1);
    cyc();
  endtask

  initial begin
    int p1, p2, p3, p4, t, saved;
    rst = 1'b0; engine_on = 1'b0; rev_req = 1'b0; rev_req4 = 1'b0; en_hold = 1'b0;
    repeat (4) cyc();
    chk("rst_state", state_o, OFF);
    chk("rst_period", cur_period, 10);
    chk("rst_pulse", engine_rev_en, 0);
    chk("rst_ramping", ramping, 0);

    // 1: idle pulse train
    rst = 1'b1; engine_on = 1'b1;
    wait_pulse(0, p1);
    wait_pulse(0, p2);
    wait_pulse(0, p3);
    chk("idle_space_a", p2 - p1, 10);
    chk("idle_space_b", p3 - p2, 10);
    chk("idle_state", state_o, IDLE);
    chk("idle_period", cur_period, 10);
    chk("idle_ramping", ramping, 0);

    // 2: ramp up to REV
    rev_req = 1'b1;
    wait_pulse(0, p1);
    wait_pulse(0, p2);
    chk("up_period_8", cur_period, 8);
    chk("up_state", state_o, RAMP_UP);
    chk("up_ramping", ramping, 1);
    wait_pulse(0, p3);
    chk("up_reload_pre", p3 - p2, 10);
    wait_pulse(0, p4);
    chk("up_space_8", p4 - p3, 8);
    chk("up_period_6", cur_period, 6);
    wait_pulses(0, 2);
    chk("up_period_4", cur_period, 4);
    chk("rev_state", state_o, REV);
    chk("rev_ramping", ramping, 0);
    wait_pulse(0, p1);
    wait_pulse(0, p2);
    wait_pulse(0, p3);
    chk("rev_space_a", p2 - p1, 4);
    chk("rev_space_b", p3 - p2, 4);

    // REV back down to IDLE
    rev_req = 1'b0;
    wait_ticks(1);
    chk("down_state", state_o, RAMP_DOWN);
    wait_pulses(0, 2);
    chk("down_period_6", cur_period, 6);
    wait_pulses(0, 2);
    chk("down_period_8", cur_period, 8);
    wait_pulses(0, 2);
    chk("down_period_10", cur_period, 10);
    chk("down_idle", state_o, IDLE);

    // 3: abort ramp up at 6
    rev_req = 1'b1;
    wait_pulses(0, 4);
    chk("abort_period", cur_period, 6);
    chk("abort_pre_state", state_o, RAMP_UP);
    rev_req = 1'b0;
    wait_ticks(1);
    chk("abort_state", state_o, RAMP_DOWN);
    chk("abort_no_jump", cur_period, 6);
    chk("abort_ramping", ramping, 1);
    wait_pulses(0, 2);
    chk("abort_period_8", cur_period, 8);
    wait_pulses(0, 2);
    chk("abort_period_10", cur_period, 10);
    chk("abort_idle", state_o, IDLE);
    chk("abort_idle_ramp", ramping, 0);

    // divider clears on state change
    rev_req = 1'b1;
    wait_pulses(0, 1);
    rev_req = 1'b0;
    wait_pulses(0, 1);
    chk("divclr_state", state_o, RAMP_DOWN);
    wait_pulses(0, 1);
    chk("divclr_idle", state_o, IDLE);
    chk("divclr_period", cur_period, 10);

    // 4: STEP=4 saturates at REV
    wait_pulse(1, t);
    rev_req4 = 1'b1;
    wait_pulses(1, 2);
    chk("s4_period_6", cur_period4, 6);
    chk("s4_state_up", state4, RAMP_UP);
    wait_pulses(1, 2);
    chk("s4_period_4", cur_period4, 4);
    chk("s4_state_rev", state4, REV);

    // 5: engine off on a pulse tick in REV
    rev_req = 1'b1;
    wait_pulses(0, 6);
    chk("off_pre_state", state_o, REV);
    wait_pulse(0, t);
    for (int i = 0; i < 100 && tick_no < t + 3; i++) cyc();
    cyc();
    engine_on = 1'b0;
    for (int i = 0; i < 100 && tick_no < t + 4; i++) cyc();
    chk("off_tick_reached", tick_no, t + 4);
    chk("off_no_pulse", pulse_now, 0);
    cyc();
    chk("off_state", state_o, OFF);
    chk("off_period", cur_period, 10);
    saved = pulse_cnt;
    wait_ticks(50);
    chk("off_silent", pulse_cnt, saved);

    // 6: sync reset mid-ramp with the enable held low
    engine_on = 1'b1;
    wait_pulses(0, 2);
    chk("r6_period", cur_period, 8);
    en_hold = 1'b1;
    repeat (6) cyc();
    chk("hold_state", state_o, RAMP_UP);
    chk("hold_period", cur_period, 8);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("r6_state", state_o, OFF);
    chk("r6_period10", cur_period, 10);
    chk("r6_pulse", engine_rev_en, 0);
    chk("r6_ramping", ramping, 0);
    saved = pulse_cnt;
    repeat (20) cyc();
    chk("frozen_state", state_o, OFF);
    chk("frozen_period", cur_period, 10);
    chk("frozen_pulses", pulse_cnt, saved);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
